// File: rtl/axis_stream_joiner_if.sv
// AXI-Stream bundle for the joiner: LANES parallel channels sharing one interface.
// The input side uses LANES=NUM_IN; the joined output uses LANES=1 with packed width.
interface axis_stream_joiner_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 64,
    parameter int USER_W = 8
);
    logic [LANES-1:0]        valid;
    logic [LANES-1:0]        ready;
    logic [LANES-1:0]        last;
    logic [LANES*DATA_W-1:0] data;
    logic [LANES*USER_W-1:0] user;

    modport master (output valid, output last, output data, output user, input  ready);
    modport slave  (input  valid, input  last, input  data, input  user, output ready);
endinterface

// File: rtl/axis_stream_joiner.sv
// N-input AXI-Stream join: one elastic FIFO per input, a joined beat is registered
// out only when every enabled input holds a beat. Sticky flag on tlast disagreement.
module axis_stream_joiner #(
    parameter int NUM_IN   = 2,
    parameter int DATA_W   = 64,
    parameter int USER_W   = 8,
    parameter int DEPTH    = 4,
    parameter int LAST_SEL = 0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NUM_IN-1:0]     en_mask,
    axis_stream_joiner_if.slave   s_axis,
    axis_stream_joiner_if.master  m_axis,
    output logic                  err_last
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + USER_W + DATA_W;
    localparam logic [AW:0] PTR_ONE = 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // s_ready depends only on registered FIFO state (never on s_valid); m_valid,
    // m_data, m_user and m_last are held stable while m_valid && !m_ready.

    logic [NUM_IN-1:0]        r_en_q;
    logic [NUM_IN-1:0]        w_empty;
    logic [NUM_IN-1:0]        w_full;
    logic [NUM_IN-1:0]        w_wr;
    logic [NUM_IN-1:0]        w_pop;
    logic [NUM_IN-1:0]        w_s_ready;
    logic [NUM_IN-1:0]        w_en_last;
    logic [EW-1:0]            w_head [NUM_IN];
    logic                     r_m_valid;
    logic                     r_m_last;
    logic [NUM_IN*DATA_W-1:0] r_m_data;
    logic [NUM_IN*USER_W-1:0] r_m_user;
    logic [NUM_IN*DATA_W-1:0] w_j_data;
    logic [NUM_IN*USER_W-1:0] w_j_user;
    logic                     w_j_last;
    logic                     w_j_err;
    logic                     w_idle;
    logic                     w_join;
    logic                     w_out_free;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
        logic [AW:0]   r_wr_ptr;
        logic [AW:0]   r_rd_ptr;
        logic [EW-1:0] r_mem [DEPTH];

        assign w_empty[g]   = (r_wr_ptr == r_rd_ptr);
        assign w_full[g]    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        // Disabled channels swallow beats, so they always look ready.
        assign w_s_ready[g] = aresetn && (!r_en_q[g] || !w_full[g]);
        assign w_wr[g]      = r_en_q[g] && s_axis.valid[g] && !w_full[g];
        assign w_pop[g]     = w_join && r_en_q[g];
        assign w_head[g]    = r_mem[r_rd_ptr[AW-1:0]];

        always_ff @(posedge aclk) begin
            if (w_wr[g]) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {s_axis.last[g],
                                            s_axis.user[g*USER_W +: USER_W],
                                            s_axis.data[g*DATA_W +: DATA_W]};
            end
        end

        // A disabled FIFO is kept drained so nothing stale survives a re-enable.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr[g]) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (!r_en_q[g])    r_rd_ptr <= r_wr_ptr;
                else if (w_pop[g]) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign s_axis.ready = w_s_ready;

    assign w_out_free = !r_m_valid || m_axis.ready[0];
    assign w_idle     = (&w_empty) && !r_m_valid;
    assign w_join     = (|r_en_q) && (&(~w_empty | ~r_en_q)) && w_out_free;

    always_comb begin
        w_j_data  = '0;
        w_j_user  = '0;
        w_en_last = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_en_q[i]) begin
                w_j_data[i*DATA_W +: DATA_W] = w_head[i][DATA_W-1:0];
                w_j_user[i*USER_W +: USER_W] = w_head[i][DATA_W +: USER_W];
                w_en_last[i]                 = w_head[i][EW-1];
            end
        end
        w_j_last = r_en_q[LAST_SEL] ? w_en_last[LAST_SEL] : (|w_en_last);
        w_j_err  = (w_en_last != '0) && (w_en_last != r_en_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_user  <= '0;
            err_last  <= 1'b0;
            r_en_q    <= '1;
        end else begin
            if (w_join) begin
                r_m_valid <= 1'b1;
                r_m_last  <= w_j_last;
                r_m_data  <= w_j_data;
                r_m_user  <= w_j_user;
            end else if (r_m_valid && m_axis.ready[0]) begin
                r_m_valid <= 1'b0;
            end
            if (w_join && w_j_err) err_last <= 1'b1;
            if (w_idle) r_en_q <= en_mask;
        end
    end

    assign m_axis.valid = r_m_valid;
    assign m_axis.last  = r_m_last;
    assign m_axis.data  = r_m_data;
    assign m_axis.user  = r_m_valid ? r_m_user : '0;
endmodule

// File: tb/tb_axis_stream_joiner.sv
// Directed bench for axis_stream_joiner (2 inputs, DEPTH 4): skew, backpressure,
// latency/throughput, tlast checking, enable mask and mid-traffic reset.
module tb_axis_stream_joiner;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int BW = 1 + 2*UW + 2*DW;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [DW-1:0] data;
    } beat_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [1:0] en_mask;
    logic       err_last;

    beat_t          src0[$];
    beat_t          src1[$];
    logic [BW-1:0]  got_q[$];
    logic [BW-1:0]  exp_q[$];
    logic           vld_log[$];
    int             n_cmp = 0;
    int             n_err = 0;
    int             hs0, hs1, tick_no, first_hs;

    always #5 aclk = ~aclk;

    axis_stream_joiner_if #(.LANES(2), .DATA_W(DW),   .USER_W(UW))   s_if ();
    axis_stream_joiner_if #(.LANES(1), .DATA_W(2*DW), .USER_W(2*UW)) m_if ();

    axis_stream_joiner #(
        .NUM_IN(2), .DATA_W(DW), .USER_W(UW), .DEPTH(4), .LAST_SEL(0)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .en_mask  (en_mask),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .err_last (err_last)
    );

    function automatic beat_t b0(input int n, input logic l);
        beat_t b;
        b.last = l;
        b.user = 8'h10 + 8'(n);
        b.data = 64'hA0A0_0000_0000_0000 + 64'(n);
        return b;
    endfunction

    function automatic beat_t b1(input int n, input logic l);
        beat_t b;
        b.last = l;
        b.user = 8'h20 + 8'(n);
        b.data = 64'hB0B0_0000_0000_0000 + 64'(n);
        return b;
    endfunction

    function automatic logic [BW-1:0] pack_exp(input logic l, input beat_t c1, input beat_t c0);
        return {l, c1.user, c0.user, c1.data, c0.data};
    endfunction

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        vld_log.delete();
        hs0 = 0;
        hs1 = 0;
        tick_no = 0;
        first_hs = -1;
    endtask

    // Drive heads of the source queues, sample #1 later, then advance one cycle.
    task automatic tick(input int n);
        repeat (n) begin
            s_if.valid[0] = (src0.size() > 0);
            s_if.valid[1] = (src1.size() > 0);
            s_if.last[0]  = (src0.size() > 0) ? src0[0].last : 1'b0;
            s_if.last[1]  = (src1.size() > 0) ? src1[0].last : 1'b0;
            s_if.user[7:0]   = (src0.size() > 0) ? src0[0].user : '0;
            s_if.user[15:8]  = (src1.size() > 0) ? src1[0].user : '0;
            s_if.data[63:0]   = (src0.size() > 0) ? src0[0].data : '0;
            s_if.data[127:64] = (src1.size() > 0) ? src1[0].data : '0;
            #1;
            vld_log.push_back(m_if.valid[0]);
            if (s_if.valid[0] && s_if.ready[0]) begin
                void'(src0.pop_front());
                hs0++;
                if (first_hs < 0) first_hs = tick_no;
            end
            if (s_if.valid[1] && s_if.ready[1]) begin
                void'(src1.pop_front());
                hs1++;
                if (first_hs < 0) first_hs = tick_no;
            end
            if (m_if.valid[0] && m_if.ready[0])
                got_q.push_back({m_if.last[0], m_if.user, m_if.data});
            tick_no++;
            @(negedge aclk);
        end
    endtask

    task automatic test_reset();
        en_mask = 2'b11;
        m_if.ready = 1'b1;
        s_if.valid = '0;
        s_if.last  = '0;
        s_if.user  = '0;
        s_if.data  = '0;
        repeat (2) @(negedge aclk);
        #1;
        n_cmp++; if (s_if.ready !== 2'b00) begin n_err++; $display("FAIL rst_s_ready got=%b exp=00", s_if.ready); end
        n_cmp++; if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got=%b exp=0", m_if.valid); end
        n_cmp++; if (m_if.data !== '0) begin n_err++; $display("FAIL rst_m_data got=%h exp=0", m_if.data); end
        n_cmp++; if (m_if.user !== '0) begin n_err++; $display("FAIL rst_m_user got=%h exp=0", m_if.user); end
        n_cmp++; if (m_if.last !== 1'b0) begin n_err++; $display("FAIL rst_m_last got=%b exp=0", m_if.last); end
        n_cmp++; if (err_last !== 1'b0) begin n_err++; $display("FAIL rst_err_last got=%b exp=0", err_last); end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        n_cmp++; if (s_if.ready !== 2'b11) begin n_err++; $display("FAIL post_rst_s_ready got=%b exp=11", s_if.ready); end
        @(negedge aclk);
    endtask

    task automatic test_skew();
        logic [BW-1:0] g, e;
        clear_sb();
        m_if.ready = 1'b1;
        for (int n = 0; n < 3; n++) src0.push_back(b0(n, 1'b0));
        tick(6);
        n_cmp++; if (hs0 !== 3) begin n_err++; $display("FAIL skew_hs0 got=%0d exp=3", hs0); end
        n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL skew_no_out got=%0d exp=0", got_q.size()); end
        n_cmp++; if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL skew_m_valid got=%b exp=0", m_if.valid); end
        n_cmp++; if (s_if.ready[0] !== 1'b1) begin n_err++; $display("FAIL skew_s_ready0 got=%b exp=1", s_if.ready[0]); end
        for (int n = 0; n < 3; n++) begin
            src1.push_back(b1(n, 1'b0));
            exp_q.push_back(pack_exp(1'b0, b1(n, 1'b0), b0(n, 1'b0)));
        end
        tick(8);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL skew_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL skew_beat got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] g, e;
        clear_sb();
        m_if.ready = 1'b0;
        for (int n = 16; n < 24; n++) begin
            src0.push_back(b0(n, 1'b0));
            src1.push_back(b1(n, 1'b0));
            exp_q.push_back(pack_exp(1'b0, b1(n, 1'b0), b0(n, 1'b0)));
        end
        tick(12);
        n_cmp++; if (hs0 !== 5) begin n_err++; $display("FAIL bp_hs0 got=%0d exp=5", hs0); end
        n_cmp++; if (hs1 !== 5) begin n_err++; $display("FAIL bp_hs1 got=%0d exp=5", hs1); end
        n_cmp++; if (s_if.ready !== 2'b00) begin n_err++; $display("FAIL bp_s_ready got=%b exp=00", s_if.ready); end
        n_cmp++; if (m_if.valid !== 1'b1) begin n_err++; $display("FAIL bp_m_valid got=%b exp=1", m_if.valid); end
        n_cmp++; if (m_if.data !== {b1(16, 1'b0).data, b0(16, 1'b0).data}) begin n_err++; $display("FAIL bp_hold_data got=%h", m_if.data); end
        m_if.ready = 1'b1;
        tick(16);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL bp_beat got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_latency();
        logic [BW-1:0] g, e;
        logic ev;
        clear_sb();
        m_if.ready = 1'b1;
        for (int n = 32; n < 38; n++) begin
            src0.push_back(b0(n, 1'b0));
            src1.push_back(b1(n, 1'b0));
            exp_q.push_back(pack_exp(1'b0, b1(n, 1'b0), b0(n, 1'b0)));
        end
        tick(12);
        n_cmp++; if (first_hs !== 0) begin n_err++; $display("FAIL lat_first_hs got=%0d exp=0", first_hs); end
        for (int k = 0; k < 12; k++) begin
            ev = (k >= 2 && k <= 7);
            n_cmp++; if (vld_log[k] !== ev) begin n_err++; $display("FAIL lat_valid_t%0d got=%b exp=%b", k, vld_log[k], ev); end
        end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL lat_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL lat_beat got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_last_err();
        logic [BW-1:0] g, e;
        clear_sb();
        m_if.ready = 1'b1;
        n_cmp++; if (err_last !== 1'b0) begin n_err++; $display("FAIL err_before got=%b exp=0", err_last); end
        for (int k = 0; k < 5; k++) begin
            src0.push_back(b0(48 + k, k == 3));
            src1.push_back(b1(48 + k, 1'b0));
            exp_q.push_back(pack_exp(k == 3, b1(48 + k, 1'b0), b0(48 + k, k == 3)));
        end
        tick(10);
        n_cmp++; if (err_last !== 1'b1) begin n_err++; $display("FAIL err_set got=%b exp=1", err_last); end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL last_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL last_beat got=%h exp=%h", g, e); end
        end
        tick(5);
        n_cmp++; if (err_last !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%b exp=1", err_last); end
    endtask

    task automatic test_mask();
        logic [BW-1:0] g, e;
        beat_t z;
        z = '0;
        clear_sb();
        m_if.ready = 1'b1;
        en_mask = 2'b01;
        tick(2);
        for (int n = 64; n < 68; n++) src1.push_back(b1(n, 1'b0));
        tick(6);
        n_cmp++; if (hs1 !== 4) begin n_err++; $display("FAIL mask_discard_hs1 got=%0d exp=4", hs1); end
        n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL mask_no_out got=%0d exp=0", got_q.size()); end
        n_cmp++; if (s_if.ready[1] !== 1'b1) begin n_err++; $display("FAIL mask_s_ready1 got=%b exp=1", s_if.ready[1]); end
        for (int n = 68; n < 71; n++) begin
            src0.push_back(b0(n, 1'b0));
            exp_q.push_back(pack_exp(1'b0, z, b0(n, 1'b0)));
        end
        tick(8);
        // Mask change while busy must not stall the ch0-only burst.
        m_if.ready = 1'b0;
        hs0 = 0;
        for (int n = 72; n < 78; n++) begin
            src0.push_back(b0(n, 1'b0));
            exp_q.push_back(pack_exp(1'b0, z, b0(n, 1'b0)));
        end
        tick(3);
        en_mask = 2'b11;
        tick(6);
        n_cmp++; if (hs0 !== 5) begin n_err++; $display("FAIL mask_cap_hs0 got=%0d exp=5", hs0); end
        m_if.ready = 1'b1;
        tick(14);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL mask_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL mask_beat got=%h exp=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
        for (int n = 80; n < 82; n++) src0.push_back(b0(n, 1'b0));
        tick(6);
        n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL mask_reen_wait got=%0d exp=0", got_q.size()); end
        for (int n = 80; n < 82; n++) begin
            src1.push_back(b1(n, 1'b0));
            exp_q.push_back(pack_exp(1'b0, b1(n, 1'b0), b0(n, 1'b0)));
        end
        tick(8);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL mask_reen_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL mask_reen_beat got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] g, e;
        clear_sb();
        m_if.ready = 1'b0;
        for (int n = 96; n < 99; n++) begin
            src0.push_back(b0(n, 1'b0));
            src1.push_back(b1(n, 1'b0));
        end
        tick(5);
        n_cmp++; if (m_if.valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid got=%b exp=1", m_if.valid); end
        aresetn = 1'b0;
        src0.delete();
        src1.delete();
        s_if.valid = '0;
        #1;
        n_cmp++; if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL rmid_m_valid got=%b exp=0", m_if.valid); end
        n_cmp++; if (m_if.data !== '0) begin n_err++; $display("FAIL rmid_m_data got=%h exp=0", m_if.data); end
        n_cmp++; if (m_if.user !== '0) begin n_err++; $display("FAIL rmid_m_user got=%h exp=0", m_if.user); end
        n_cmp++; if (err_last !== 1'b0) begin n_err++; $display("FAIL rmid_err_last got=%b exp=0", err_last); end
        n_cmp++; if (s_if.ready !== 2'b00) begin n_err++; $display("FAIL rmid_s_ready got=%b exp=00", s_if.ready); end
        @(negedge aclk);
        aresetn = 1'b1;
        m_if.ready = 1'b1;
        clear_sb();
        tick(6);
        n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL rmid_stale got=%0d exp=0", got_q.size()); end
        n_cmp++; if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL rmid_idle_valid got=%b exp=0", m_if.valid); end
        src0.push_back(b0(100, 1'b0));
        src1.push_back(b1(100, 1'b0));
        exp_q.push_back(pack_exp(1'b0, b1(100, 1'b0), b0(100, 1'b0)));
        tick(5);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL rmid_beat got=%h exp=%h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_backpressure();
        test_latency();
        test_last_err();
        test_mask();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
